// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART debug/loader bus master.
// State encoding, command/response codes, timer width and a byte-XOR helper.
package uart_bus_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_TX_START,
    S_TX_WAIT
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam int TIMEOUT_W = 32;

  // XOR of the four bytes of a word, used for the response checksum byte.
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

endpackage

// File: rtl/uart_tx_queue.sv
// Response byte queue: holds up to 5 bytes and a count, sends them in order
// through the async transmitter handshake and pulses done_o when the last
// byte has left the transmitter.
module uart_tx_queue
  import uart_bus_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [39:0] bytes_i,
  input  logic [2:0]  count_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        done_o
);

  state_t      r_state;
  logic [39:0] r_bytes;
  logic [2:0]  r_count;
  logic        r_guard;

  // Start/wait sequencing; the guard cycle lets the transmitter raise busy
  // before we look at it again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bytes    <= '0;
      r_count    <= '0;
      r_guard    <= 1'b0;
      txdStart_o <= 1'b0;
      txdData_o  <= '0;
      done_o     <= 1'b0;
    end else begin
      txdStart_o <= 1'b0;
      done_o     <= 1'b0;
      case (r_state)
        S_TX_START: begin
          if (!txdBusy_i) begin
            txdData_o  <= r_bytes[7:0];
            txdStart_o <= 1'b1;
            r_bytes    <= {8'h00, r_bytes[39:8]};
            r_count    <= r_count - 3'd1;
            r_guard    <= 1'b1;
            r_state    <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (r_guard) begin
            r_guard <= 1'b0;
          end else if (!txdBusy_i) begin
            if (r_count != 3'd0) begin
              r_state <= S_TX_START;
            end else begin
              done_o  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          if (load_i) begin
            r_bytes <= bytes_i;
            r_count <= count_i;
            r_state <= S_TX_START;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven single-word bus initiator. Parses 'R'/'W' frames, runs one bus
// cycle and returns read data, ACK or NAK through uart_tx_queue.
// Optional build macro: UART_BUS_MASTER_CHECKSUM_EN adds a trailing XOR byte
// to every received frame and every response.
//
// state      | meaning
// S_IDLE     | waiting for a command byte
// S_ADDR     | collecting address bytes A0..A3
// S_DATA     | collecting write data D0..D3 (and checksum byte when enabled)
// S_BUS      | bus request held until the target stops reporting busy
// S_TX_START | response handed to the queue, waiting for its done pulse
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int TIMEOUT_MS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        devEnable_o,
  output logic        devWrite_o,
  input  logic        devBusy_i,
  output logic [31:0] devDataSave_o,
  input  logic [31:0] devDataLoad_i,
  output logic [31:0] devPhysicalAddr_o,
  output logic [3:0]  devByteSelect_o,
  output logic        active_o
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(CLK_FREQ / 1000 * TIMEOUT_MS);

`ifdef UART_BUS_MASTER_CHECKSUM_EN
  localparam logic [2:0] CK_EXTRA = 3'd1;
`else
  localparam logic [2:0] CK_EXTRA = 3'd0;
`endif

  state_t                r_state;
  logic [1:0]            r_idx;
  logic [TIMEOUT_W-1:0]  r_timer;
  logic                  r_q_load;
  logic [39:0]           r_q_bytes;
  logic [2:0]            r_q_count;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
  logic [7:0]            r_csum;
  logic                  r_ck_phase;
`endif

  logic w_in_frame;
  logic w_expired;
  logic w_q_done;

  assign devByteSelect_o = 4'hf;
  assign w_in_frame      = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_expired       = w_in_frame && (r_timer == '0);

  // Inter-byte timeout: reload on any byte, count down only mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= TIMEOUT_CYC;
    end else if (rxdReady_i) begin
      r_timer <= TIMEOUT_CYC;
    end else if (w_in_frame && (r_timer != '0)) begin
      r_timer <= r_timer - TIMEOUT_W'(1);
    end
  end

  // Frame parser and bus sequencer; responses are always built as payload
  // plus XOR byte, and the count decides whether the XOR byte is sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_idx             <= '0;
      r_q_load          <= 1'b0;
      r_q_bytes         <= '0;
      r_q_count         <= '0;
      devEnable_o       <= 1'b0;
      devWrite_o        <= 1'b0;
      devDataSave_o     <= '0;
      devPhysicalAddr_o <= '0;
      active_o          <= 1'b0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      r_csum            <= '0;
      r_ck_phase        <= 1'b0;
`endif
    end else begin
      r_q_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rxdReady_i) begin
            active_o <= 1'b1;
            if ((rxdData_i == CMD_READ) || (rxdData_i == CMD_WRITE)) begin
              devWrite_o <= (rxdData_i == CMD_WRITE);
              r_idx      <= '0;
              r_state    <= S_ADDR;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
              r_csum     <= rxdData_i;
              r_ck_phase <= 1'b0;
`endif
            end else begin
              r_q_bytes <= {24'h0, RSP_NAK, RSP_NAK};
              r_q_count <= 3'd1 + CK_EXTRA;
              r_q_load  <= 1'b1;
              r_state   <= S_TX_START;
            end
          end
        end
        S_ADDR: begin
          if (w_expired) begin
            r_state  <= S_IDLE;
            active_o <= 1'b0;
          end else if (rxdReady_i) begin
            devPhysicalAddr_o[{r_idx, 3'b000} +: 8] <= rxdData_i;
            r_idx <= r_idx + 2'd1;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            r_csum <= r_csum ^ rxdData_i;
`endif
            if (r_idx == 2'd3) begin
              if (devWrite_o) begin
                r_state <= S_DATA;
              end else begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
                r_ck_phase <= 1'b1;
                r_state    <= S_DATA;
`else
                devEnable_o <= 1'b1;
                r_state     <= S_BUS;
`endif
              end
            end
          end
        end
        S_DATA: begin
          if (w_expired) begin
            r_state  <= S_IDLE;
            active_o <= 1'b0;
          end else if (rxdReady_i) begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            if (r_ck_phase) begin
              if ((r_csum ^ rxdData_i) == 8'h00) begin
                devEnable_o <= 1'b1;
                r_state     <= S_BUS;
              end else begin
                r_q_bytes <= {24'h0, RSP_NAK, RSP_NAK};
                r_q_count <= 3'd1 + CK_EXTRA;
                r_q_load  <= 1'b1;
                r_state   <= S_TX_START;
              end
            end else begin
              devDataSave_o[{r_idx, 3'b000} +: 8] <= rxdData_i;
              r_idx  <= r_idx + 2'd1;
              r_csum <= r_csum ^ rxdData_i;
              if (r_idx == 2'd3) r_ck_phase <= 1'b1;
            end
`else
            devDataSave_o[{r_idx, 3'b000} +: 8] <= rxdData_i;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              devEnable_o <= 1'b1;
              r_state     <= S_BUS;
            end
`endif
          end
        end
        S_BUS: begin
          if (devEnable_o && !devBusy_i) begin
            devEnable_o <= 1'b0;
            r_q_load    <= 1'b1;
            r_state     <= S_TX_START;
            if (devWrite_o) begin
              r_q_bytes <= {24'h0, RSP_ACK, RSP_ACK};
              r_q_count <= 3'd1 + CK_EXTRA;
            end else begin
              r_q_bytes <= {xor_bytes(devDataLoad_i), devDataLoad_i};
              r_q_count <= 3'd4 + CK_EXTRA;
            end
          end
        end
        S_TX_START: begin
          if (w_q_done) begin
            r_state  <= S_IDLE;
            active_o <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          active_o <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_queue u_tx_queue (
    .clk        (clk),
    .rst        (rst),
    .load_i     (r_q_load),
    .bytes_i    (r_q_bytes),
    .count_i    (r_q_count),
    .txdBusy_i  (txdBusy_i),
    .txdStart_o (txdStart_o),
    .txdData_o  (txdData_o),
    .done_o     (w_q_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a small transmitter and bus target model.
module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam int CLK_FREQ   = 100000;
  localparam int TIMEOUT_MS = 1;
  localparam int T_CYC      = CLK_FREQ / 1000 * TIMEOUT_MS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxdReady_i = 1'b0;
  logic [7:0]  rxdData_i = 8'h00;
  logic        txdBusy_i = 1'b0;
  logic        txdStart_o;
  logic [7:0]  txdData_o;
  logic        devEnable_o;
  logic        devWrite_o;
  logic        devBusy_i = 1'b0;
  logic [31:0] devDataSave_o;
  logic [31:0] devDataLoad_i = 32'h0;
  logic [31:0] devPhysicalAddr_o;
  logic [3:0]  devByteSelect_o;
  logic        active_o;

  always #5 clk = ~clk;

  uart_bus_master #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk(clk), .rst(rst),
    .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
    .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o),
    .devEnable_o(devEnable_o), .devWrite_o(devWrite_o), .devBusy_i(devBusy_i),
    .devDataSave_o(devDataSave_o), .devDataLoad_i(devDataLoad_i),
    .devPhysicalAddr_o(devPhysicalAddr_o), .devByteSelect_o(devByteSelect_o),
    .active_o(active_o)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame[$];

  int   tx_cnt = 0;
  int   start_busy_viol = 0;
  int   start_width_viol = 0;
  logic prev_start = 1'b0;

  int          bus_cycles = 0;
  int          en_cycles = 0;
  int          bus_unstable = 0;
  int          busy_left = 0;
  logic        prev_en = 1'b0;
  logic [31:0] seen_addr = 32'h0;
  logic [31:0] seen_data = 32'h0;
  logic        seen_write = 1'b0;
  logic [3:0]  seen_bsel = 4'h0;

  // Transmitter model: captures each started byte and stays busy 4 cycles.
  always @(negedge clk) begin
    if (txdStart_o) begin
      if (prev_start) start_width_viol++;
      if (txdBusy_i) start_busy_viol++;
      rx_q.push_back(txdData_o);
      txdBusy_i = 1'b1;
      tx_cnt = 4;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) txdBusy_i = 1'b0;
    end
    prev_start = txdStart_o;
  end

  // Bus target model: busy for busy_left enabled cycles, records the request.
  always @(negedge clk) begin
    if (devEnable_o) begin
      en_cycles++;
      if (!prev_en) begin
        bus_cycles++;
        seen_addr  = devPhysicalAddr_o;
        seen_data  = devDataSave_o;
        seen_write = devWrite_o;
        seen_bsel  = devByteSelect_o;
      end else if (seen_addr !== devPhysicalAddr_o || seen_data !== devDataSave_o ||
                   seen_write !== devWrite_o) begin
        bus_unstable++;
      end
      if (busy_left > 0) begin
        devBusy_i = 1'b1;
        busy_left--;
      end else begin
        devBusy_i = 1'b0;
      end
    end else begin
      devBusy_i = 1'b0;
    end
    prev_en = devEnable_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxdData_i  = b;
    rxdReady_i = 1'b1;
    @(negedge clk);
    rxdReady_i = 1'b0;
  endtask

  task automatic send_frame();
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
`endif
    foreach (frame[i]) send_byte(frame[i]);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((active_o || tx_cnt != 0) && n < budget);
    check({tag, "_idle"}, {31'h0, (n < budget)}, 32'h1);
  endtask

  task automatic check_rsp(input string tag);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
    check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hxxxxxxxx,
            {24'h0, exp_q[i]});
  endtask

  task automatic clear_stats();
    rx_q.delete();
    exp_q.delete();
    bus_cycles = 0;
    en_cycles = 0;
    bus_unstable = 0;
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_active", {31'h0, active_o}, 32'h0);
    check("rst_en", {31'h0, devEnable_o}, 32'h0);
    check("rst_wr", {31'h0, devWrite_o}, 32'h0);
    check("rst_start", {31'h0, txdStart_o}, 32'h0);
    check("rst_txd", {24'h0, txdData_o}, 32'h0);
    check("rst_addr", devPhysicalAddr_o, 32'h0);
    check("rst_wdata", devDataSave_o, 32'h0);
    check("rst_bsel", {28'h0, devByteSelect_o}, 32'hf);

    // write with 3 busy cycles
    clear_stats();
    busy_left = 3;
    frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    wait_idle("wr", 300);
    check("wr_buscycles", bus_cycles, 1);
    check("wr_encycles", en_cycles, 4);
    check("wr_addr", seen_addr, 32'h80000000);
    check("wr_data", seen_data, 32'hDEADBEEF);
    check("wr_flag", {31'h0, seen_write}, 32'h1);
    check("wr_bsel", {28'h0, seen_bsel}, 32'hf);
    check("wr_stable", bus_unstable, 0);
    exp_q = '{8'h06};
    check_rsp("wr_rsp");

    // read, with a stray byte during the response that must be dropped
    clear_stats();
    devDataLoad_i = 32'h12345678;
    frame = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
    send_frame();
    for (int n = 0; n < 200 && rx_q.size() == 0; n++) @(negedge clk);
    check("rd_first_byte_seen", {31'h0, (rx_q.size() != 0)}, 32'h1);
    send_byte(8'h41);
    wait_idle("rd", 400);
    check("rd_buscycles", bus_cycles, 1);
    check("rd_encycles", en_cycles, 1);
    check("rd_addr", seen_addr, 32'h80000004);
    check("rd_flag", {31'h0, seen_write}, 32'h0);
    exp_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    check_rsp("rd_rsp");
    check("rd_start_busy", start_busy_viol, 0);
    check("rd_start_width", start_width_viol, 0);

    // unknown command
    clear_stats();
    send_byte(8'h41);
    wait_idle("nak", 200);
    check("nak_buscycles", bus_cycles, 0);
    exp_q = '{8'h15};
    check_rsp("nak_rsp");

    // timeout mid-address
    clear_stats();
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (T_CYC) @(negedge clk);
    check("to_active_before", {31'h0, active_o}, 32'h1);
    @(negedge clk);
    check("to_active_after", {31'h0, active_o}, 32'h0);
    repeat (10) @(negedge clk);
    check("to_buscycles", bus_cycles, 0);
    check("to_rsp_len", 32'(rx_q.size()), 32'h0);

    // next frame after timeout
    clear_stats();
    devDataLoad_i = 32'hCAFEF00D;
    frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h80};
    send_frame();
    wait_idle("rd2", 400);
    check("rd2_buscycles", bus_cycles, 1);
    check("rd2_addr", seen_addr, 32'h80000000);
    exp_q = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    check_rsp("rd2_rsp");

    // reset while the target holds busy
    clear_stats();
    busy_left = 1000;
    frame = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h80};
    send_frame();
    for (int n = 0; n < 50 && !devEnable_o; n++) @(negedge clk);
    check("rb_en_seen", {31'h0, devEnable_o}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rb_en", {31'h0, devEnable_o}, 32'h0);
    check("rb_active", {31'h0, active_o}, 32'h0);
    check("rb_addr", devPhysicalAddr_o, 32'h0);
    check("rb_wr", {31'h0, devWrite_o}, 32'h0);
    check("rb_txd", {24'h0, txdData_o}, 32'h0);
    check("rb_start", {31'h0, txdStart_o}, 32'h0);
    busy_left = 0;
    repeat (30) @(negedge clk);
    check("rb_rsp_len", 32'(rx_q.size()), 32'h0);
    check("rb_buscycles", bus_cycles, 1);

`ifdef UART_BUS_MASTER_CHECKSUM_EN
    // explicit checksum frames
    clear_stats();
    devDataLoad_i = 32'h12345678;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h80); send_byte(8'hD2);
    wait_idle("ck", 400);
    check("ck_buscycles", bus_cycles, 1);
    check("ck_len", 32'(rx_q.size()), 32'd5);
    check("ck_last", (rx_q.size() == 5) ? {24'h0, rx_q[4]} : 32'hxxxxxxxx, 32'h08);
    clear_stats();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h80); send_byte(8'h00);
    wait_idle("ckbad", 200);
    check("ckbad_buscycles", bus_cycles, 0);
    check("ckbad_len", 32'(rx_q.size()), 32'd2);
    check("ckbad_b0", (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'hxxxxxxxx, 32'h15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
